// File: rtl/backward_space_pkg.sv
// Shared constants, state encodings and coefficient tables for the Lab -> RGB path.
// Every fixed-point constant is Q8 (1.0 == 256) unless noted otherwise.
package backward_space_pkg;

    localparam int SIZE_INT  = 32;
    localparam int SCALE_BIT = 8;

    // L* is clamped to 100.0 before use; 4096 is 16.0 in Q8.
    localparam int L_MAX    = 25600;
    localparam int L_OFFSET = 4096;

    // Reciprocals in Q16: 1/116, 1/500, 1/200.
    localparam int RECIP_L = 565;
    localparam int RECIP_A = 131;
    localparam int RECIP_B = 328;

    // Inverse companding: cubic above the knee, linear segment below it.
    localparam int F_THRESH = 53;
    localparam int F_KNEE   = 35;
    localparam int F_SLOPE  = 33;

    localparam int WHITE_X = 243;
    localparam int WHITE_Y = 256;
    localparam int WHITE_Z = 279;

    localparam int NUM_STEPS = 21;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_SAT  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        DST_NONE = 3'd0,
        DST_FY   = 3'd1,
        DST_FX   = 3'd2,
        DST_FZ   = 3'd3,
        DST_TMP  = 3'd4,
        DST_XYZ  = 3'd5
    } dst_t;

    function automatic int white_coef(input logic [1:0] ch);
        int c;
        case (ch)
            2'd0:    c = WHITE_X;
            2'd1:    c = WHITE_Y;
            default: c = WHITE_Z;
        endcase
        return c;
    endfunction

    // Row selects the output channel (R,G,B), column the XYZ input.
    function automatic int xyz2rgb_coef(input logic [1:0] row, input logic [1:0] col);
        int c;
        case ({row, col})
            4'h0:    c = 830;
            4'h1:    c = -394;
            4'h2:    c = -128;
            4'h4:    c = -248;
            4'h5:    c = 480;
            4'h6:    c = 11;
            4'h8:    c = 14;
            4'h9:    c = -52;
            4'hA:    c = 271;
            default: c = 0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/backward_space_mac.sv
// lab_mac_unit: one signed multiplier with selectable arithmetic right shift, plus an
// accumulator that can restart or add, and an 8-bit clamp of acc >> FRAC. Combinational product.
module lab_mac_unit #(
    parameter int W    = 32,
    parameter int FRAC = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic signed [W-1:0] op_a,
    input  logic signed [W-1:0] op_b,
    input  logic [5:0]          shamt,
    input  logic                acc_start,
    input  logic                acc_add,
    output logic signed [W-1:0] result,
    output logic [7:0]          acc_sat
);

    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] acc;
    logic signed [2*W-1:0] acc_shr;

    assign prod   = (2*W)'(op_a) * (2*W)'(op_b);
    assign result = W'(prod >>> shamt);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (acc_start) begin
            acc <= prod;
        end else if (acc_add) begin
            acc <= acc + prod;
        end
    end

    assign acc_shr = acc >>> FRAC;

    always_comb begin
        acc_sat = 8'd0;
        if (acc_shr < 0) begin
            acc_sat = 8'd0;
        end else if (acc_shr > (2*W)'(255)) begin
            acc_sat = 8'd255;
        end else begin
            acc_sat = 8'(acc_shr);
        end
    end

endmodule

// File: rtl/backward_space.sv
// CIELab (Q8) -> XYZ -> saturated 8-bit RGB on one shared multiplier, one pixel in flight.
// Output valid 22 cycles after acceptance; result held until out_ready, in_ready low while busy.
module backward_space
    import backward_space_pkg::*;
#(
    parameter int size_int = SIZE_INT,
    parameter int ScaleBit = SCALE_BIT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [size_int-1:0] CIEL,
    input  logic [size_int-1:0] CIEa,
    input  logic [size_int-1:0] CIEb,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          R,
    output logic [7:0]          G,
    output logic [7:0]          B
);

    localparam logic signed [size_int-1:0] THRESH  = size_int'(F_THRESH);
    localparam logic signed [size_int-1:0] KNEE    = size_int'(F_KNEE);
    localparam logic [size_int-1:0]        L_CLAMP = size_int'(L_MAX);
    localparam logic [5:0]                 SH_ONE  = 6'(ScaleBit);
    localparam logic [5:0]                 SH_TWO  = 6'(2 * ScaleBit);

    state_t state, state_nxt;
    logic [4:0] step, step_nxt;
    logic       accept;

    logic [size_int-1:0]        l_q;
    logic signed [size_int-1:0] a_q, b_q;
    logic signed [size_int-1:0] fx, fy, fz, tmp;
    logic signed [size_int-1:0] x_q, y_q, z_q;
    logic [7:0]                 r_hold, g_hold;

    logic [2:0]                 grp;
    logic [1:0]                 phase;
    logic signed [size_int-1:0] f_sel;
    logic                       cubic;
    logic signed [size_int-1:0] op_a, op_b, mac_res;
    logic [5:0]                 shamt;
    dst_t                       dst;
    logic                       acc_start, acc_add, save_r, save_g;
    logic [7:0]                 acc_sat;

    assign in_ready = (state == ST_IDLE) && !reset;
    assign accept   = in_valid && in_ready;

    // Steps 3..20 run in groups of three: groups 0-2 are X/Y/Z, groups 3-5 are the R/G/B rows.
    assign grp   = 3'((step - 5'd3) / 5'd3);
    assign phase = 2'((step - 5'd3) % 5'd3);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            step  <= '0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        op_a      = '0;
        op_b      = '0;
        shamt     = '0;
        dst       = DST_NONE;
        acc_start = 1'b0;
        acc_add   = 1'b0;
        save_r    = 1'b0;
        save_g    = 1'b0;

        case (grp[1:0])
            2'd0:    f_sel = fx;
            2'd1:    f_sel = fy;
            default: f_sel = fz;
        endcase
        cubic = (f_sel > THRESH);

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_MUL;
                    step_nxt  = '0;
                end
            end
            ST_MUL: begin
                if (step == 5'(NUM_STEPS - 1)) begin
                    state_nxt = ST_SAT;
                    step_nxt  = '0;
                end else begin
                    step_nxt = step + 5'd1;
                end

                if (step == 5'd0) begin
                    op_a  = $signed(l_q + size_int'(L_OFFSET));
                    op_b  = size_int'(RECIP_L);
                    shamt = SH_TWO;
                    dst   = DST_FY;
                end else if (step == 5'd1) begin
                    op_a  = a_q;
                    op_b  = size_int'(RECIP_A);
                    shamt = SH_TWO;
                    dst   = DST_FX;
                end else if (step == 5'd2) begin
                    op_a  = b_q;
                    op_b  = size_int'(RECIP_B);
                    shamt = SH_TWO;
                    dst   = DST_FZ;
                end else if (grp < 3'd3) begin
                    shamt = SH_ONE;
                    case (phase)
                        2'd0: begin
                            op_a = cubic ? f_sel : (f_sel - KNEE);
                            op_b = cubic ? f_sel : size_int'(F_SLOPE);
                            dst  = DST_TMP;
                        end
                        2'd1: begin
                            // The linear segment is finished after one product; idle this slot.
                            if (cubic) begin
                                op_a = tmp;
                                op_b = f_sel;
                                dst  = DST_TMP;
                            end
                        end
                        default: begin
                            op_a = tmp;
                            op_b = size_int'(white_coef(grp[1:0]));
                            dst  = DST_XYZ;
                        end
                    endcase
                end else begin
                    op_a = size_int'(xyz2rgb_coef(2'(grp - 3'd3), phase));
                    case (phase)
                        2'd0:    op_b = x_q;
                        2'd1:    op_b = y_q;
                        default: op_b = z_q;
                    endcase
                    acc_start = (phase == 2'd0);
                    acc_add   = (phase != 2'd0);
                    save_r    = (phase == 2'd0) && (grp == 3'd4);
                    save_g    = (phase == 2'd0) && (grp == 3'd5);
                end
            end
            ST_SAT: begin
                state_nxt = ST_DONE;
            end
            default: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    lab_mac_unit #(
        .W   (size_int),
        .FRAC(ScaleBit)
    ) u_mac (
        .clock    (clock),
        .reset    (reset),
        .op_a     (op_a),
        .op_b     (op_b),
        .shamt    (shamt),
        .acc_start(acc_start),
        .acc_add  (acc_add),
        .result   (mac_res),
        .acc_sat  (acc_sat)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            l_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            fx        <= '0;
            fy        <= '0;
            fz        <= '0;
            tmp       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            r_hold    <= '0;
            g_hold    <= '0;
            R         <= '0;
            G         <= '0;
            B         <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                l_q <= (CIEL > L_CLAMP) ? L_CLAMP : CIEL;
                a_q <= $signed(CIEa);
                b_q <= $signed(CIEb);
            end

            case (dst)
                DST_FY: fy <= mac_res;
                DST_FX: fx <= fy + mac_res;
                DST_FZ: fz <= fy - mac_res;
                // Cubic terms are never negative, so flooring at zero only affects the linear segment.
                DST_TMP: tmp <= (mac_res < 0) ? '0 : mac_res;
                DST_XYZ: begin
                    case (grp[1:0])
                        2'd0:    x_q <= mac_res;
                        2'd1:    y_q <= mac_res;
                        default: z_q <= mac_res;
                    endcase
                end
                default: ;
            endcase

            if (save_r) r_hold <= acc_sat;
            if (save_g) g_hold <= acc_sat;

            if (state == ST_SAT) begin
                R         <= r_hold;
                G         <= g_hold;
                B         <= acc_sat;
                out_valid <= 1'b1;
            end else if ((state == ST_DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
